spi_slave_regif: RTL and testbench
==================================

SPI_SLAVE_REGIF -- requirements
Module: spi_slave_regif

Interface
REQ-001 Parameter READ_CMD, default 8'h0F, command byte that selects a register read; any other command value is a write.
REQ-002 Parameter SYNC_STAGES, default 2, number of flip-flop synchronizer stages on spi_sclk, spi_cs_n and spi_mosi.
REQ-003 clk  input  1  system clock; all logic on its rising edge; frequency at least 16x the SCLK frequency.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 spi_sclk  input  1  SPI clock from the master; idle low while cs_n is high; asynchronous to clk.
REQ-006 spi_cs_n  input  1  active-low frame select; asynchronous to clk.
REQ-007 spi_mosi  input  1  master-out data, MSB first, valid at SCLK rising edge.
REQ-008 spi_miso  output  1  slave-out data, changes after SCLK falling edge.
REQ-009 spi_miso_oe  output  1  high while miso is driven, i.e. during the read-data phase.
REQ-010 reg_addr  output  16  register address latched from the frame.
REQ-011 reg_wr_data  output  32  write data latched from the frame.
REQ-012 reg_wr  output  1  one-clk write strobe.
REQ-013 reg_rd  output  1  one-clk read strobe.
REQ-014 reg_rd_data  input  32  read data, valid exactly 1 clk after reg_rd.
REQ-015 frame_err  output  1  one-clk pulse when a frame ends early.
REQ-016 busy  output  1  high from cs_n fall (synchronized) to cs_n rise (synchronized).

Function
REQ-017 Frame format: 8-bit command, then 16-bit address, then 32-bit data; 56 SCLK rising edges total; MSB first in each field.
REQ-018 Synchronized spi_sclk drives rise/fall detectors; each SCLK rising edge samples one mosi bit, and each falling edge advances miso.
REQ-019 FSM states: IDLE, CMD, ADDR, WDATA, RDATA, WAIT_END.
REQ-020 IDLE -> CMD on synchronized cs_n falling; bit counter cleared to 0.
REQ-021 CMD -> ADDR after 8th rising edge; ADDR -> RDATA (cmd == READ_CMD) or WDATA (otherwise) after 24th rising edge.
REQ-022 On entering RDATA: reg_rd pulsed for 1 clk with reg_addr valid; reg_rd_data captured into a 32-bit shift register on the next clk; spi_miso_oe = 1 and spi_miso = bit 31 before the 24th SCLK falling edge.
REQ-023 RDATA: each subsequent SCLK falling edge shifts miso to the next lower bit; after 32 data bits (56th rising edge) -> WAIT_END.
REQ-024 WDATA: after 56th rising edge, reg_wr_data loaded and reg_wr pulsed 1 clk with reg_addr; then -> WAIT_END.
REQ-025 WAIT_END: additional SCLK edges ignored, with no strobes and no shift; -> IDLE on synchronized cs_n rising.
REQ-026 cs_n rising in CMD, ADDR, WDATA or RDATA: frame_err pulsed 1 clk, no reg_wr issued, -> IDLE; a reg_rd already issued is not retracted.
REQ-027 spi_miso = 1 and spi_miso_oe = 0 in every state except RDATA.
REQ-028 SCLK edges while cs_n is high are ignored.
REQ-029 reg_wr and reg_rd never assert in the same clk; at most one strobe per frame.
REQ-030 Bit counter 6 bits, saturating at 56; no wrap.

Reset
REQ-031 rst high: FSM = IDLE, counter = 0, synchronizers = idle values (sclk 0, cs_n 1, mosi 1).
REQ-032 rst high: reg_addr = 0, reg_wr_data = 0, reg_wr = 0, reg_rd = 0, frame_err = 0, busy = 0, spi_miso = 1, spi_miso_oe = 0.
REQ-033 rst asserted mid-frame aborts the frame with no strobe and no frame_err; after release, the block waits for the next cs_n falling edge.

Verification
REQ-034 Write: cmd 0x02, addr 0x0010, data 0xDEADBEEF -> one reg_wr with reg_addr = 0x0010 and reg_wr_data = 0xDEADBEEF; no reg_rd.
REQ-035 Read: cmd 0x0F, addr 0x0004, reg_rd_data = 0x12345678 -> one reg_rd with addr 0x0004; master samples 0x12345678 on rising edges 25-56.
REQ-036 Early end: cs_n high after 30 edges of a write -> frame_err pulse, no reg_wr, busy low, next frame decodes correctly.
REQ-037 Back-to-back: write then read with 1 SCLK period of cs_n high between them -> both decoded, strobes in order.
REQ-038 Reset mid-read at edge 40 -> spi_miso_oe = 0, spi_miso = 1, no frame_err, subsequent write frame accepted.
REQ-039 Extra edges: 60 SCLK edges in a write frame -> exactly one reg_wr, carrying data from bits 25-56.

Source files
------------

// File: rtl/spi_slave_regif.sv
// SPI slave (mode 0) bridging 56-bit frames (cmd, addr, data) onto a simple
// register bus with one-clk read/write strobes; SPI pins are oversampled on clk.
module spi_slave_regif #(
    parameter logic [7:0] READ_CMD    = 8'h0F,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wr_data,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [31:0] reg_rd_data,
    output logic        frame_err,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, WAIT_END} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_t      state_q;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  cmd_q;
    logic [31:0] shin_q, shin_d;
    logic [31:0] shout_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_q, rd_q, rd_load_q, err_q, busy_q, miso_q, oe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    // mosi goes through the same number of stages as sclk, so it stays aligned
    // with the detected rising edge.
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    assign cnt_d  = (cnt_q >= 6'd56) ? 6'd56 : cnt_q + 6'd1;
    assign shin_d = {shin_q[30:0], mosi_s};

    // Strobes reg_wr/reg_rd/frame_err are single-clk pulses with no back-pressure;
    // reg_rd_data is expected one clk after reg_rd and is captured on rd_load_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            shin_q    <= '0;
            shout_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            rd_load_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            miso_q    <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            rd_load_q <= rd_q;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= CMD;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CMD, ADDR, WDATA, RDATA: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        miso_q  <= 1'b1;
                        oe_q    <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            cnt_q  <= cnt_d;
                            shin_q <= shin_d;
                            case (state_q)
                                CMD: begin
                                    if (cnt_d == 6'd8) begin
                                        cmd_q   <= shin_d[7:0];
                                        state_q <= ADDR;
                                    end
                                end
                                ADDR: begin
                                    if (cnt_d == 6'd24) begin
                                        addr_q <= shin_d[15:0];
                                        if (cmd_q == READ_CMD) begin
                                            state_q <= RDATA;
                                            rd_q    <= 1'b1;
                                        end else begin
                                            state_q <= WDATA;
                                        end
                                    end
                                end
                                WDATA: begin
                                    if (cnt_d == 6'd56) begin
                                        wdata_q <= shin_d;
                                        wr_q    <= 1'b1;
                                        state_q <= WAIT_END;
                                    end
                                end
                                RDATA: begin
                                    if (cnt_d == 6'd56) begin
                                        state_q <= WAIT_END;
                                        miso_q  <= 1'b1;
                                        oe_q    <= 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        // Bit 31 is presented at load; falling edges from the 25th on shift.
                        if (state_q == RDATA && rd_load_q) begin
                            shout_q <= reg_rd_data;
                            miso_q  <= reg_rd_data[31];
                            oe_q    <= 1'b1;
                        end else if (state_q == RDATA && sclk_fall && cnt_q >= 6'd25) begin
                            shout_q <= {shout_q[30:0], 1'b0};
                            miso_q  <= shout_q[30];
                        end
                    end
                end
                WAIT_END: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign reg_addr    = addr_q;
    assign reg_wr_data = wdata_q;
    assign reg_wr      = wr_q;
    assign reg_rd      = rd_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: bit-banged SPI master, register-bus responder,
// strobe monitor and a frame-level model of the expected bus events.
module tb_spi_slave_regif;

    localparam int         HALF = 10;
    localparam logic [7:0] RD   = 8'h0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sclk, spi_cs_n, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic [15:0] reg_addr;
    logic [31:0] reg_wr_data;
    logic        reg_wr, reg_rd;
    logic [31:0] reg_rd_data;
    logic        frame_err, busy;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    spi_slave_regif #(.READ_CMD(RD), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr(reg_wr),
        .reg_rd(reg_rd), .reg_rd_data(reg_rd_data), .frame_err(frame_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         obs_q[$];
    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_cnt = 0;
    int          both_cnt = 0;
    int          exp_err;
    logic [31:0] rd_val = 32'h0;
    logic        rx_miso[1:64];
    logic        rx_oe[1:64];
    logic        rx_busy[1:64];
    logic        rst_miso, rst_oe;

    // Register-bus responder: data is only meaningful the clk after reg_rd.
    always @(posedge clk) reg_rd_data <= reg_rd ? rd_val : $urandom;

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_wr && reg_rd) both_cnt++;
            if (reg_wr) obs_q.push_back(ev_t'{1'b1, reg_addr, reg_wr_data});
            if (reg_rd) obs_q.push_back(ev_t'{1'b0, reg_addr, 32'h0});
            if (frame_err) err_cnt++;
        end
    end

    function automatic logic [99:0] ev_sig(input ev_t q[$]);
        logic [99:0] s = '0;
        s[99:98] = (q.size() > 3) ? 2'd3 : 2'(q.size());
        if (q.size() > 0) s[97:49] = q[0];
        if (q.size() > 1) s[48:0] = q[1];
        return s;
    endfunction

    // Frame-level reference: what the register bus should see for this frame.
    function automatic void model(input logic [55:0] f, input int nedges, input int rst_at);
        int last;
        last = (rst_at > 0) ? rst_at : nedges;
        if (last >= 24 && f[55:48] == RD) exp_q.push_back(ev_t'{1'b0, f[47:32], 32'h0});
        if (last >= 56 && f[55:48] != RD) exp_q.push_back(ev_t'{1'b1, f[47:32], f[31:0]});
        exp_err = (rst_at == 0 && nedges < 56) ? 1 : 0;
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        err_cnt = 0;
    endtask

    task automatic spi_xfer(input logic [55:0] f, input int nedges, input int rst_at, input int gap);
        foreach (rx_miso[i]) begin
            rx_miso[i] = 1'bx;
            rx_oe[i]   = 1'bx;
            rx_busy[i] = 1'bx;
        end
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int e = 1; e <= nedges; e++) begin
            spi_mosi = (e <= 56) ? f[56-e] : 1'($urandom);
            repeat (HALF) @(negedge clk);
            spi_sclk   = 1'b1;
            rx_miso[e] = spi_miso;
            rx_oe[e]   = spi_miso_oe;
            rx_busy[e] = busy;
            if (e == rst_at) begin
                repeat (3) @(negedge clk);
                rst      = 1'b1;
                spi_sclk = 1'b0;
                spi_cs_n = 1'b1;
                spi_mosi = 1'b1;
                repeat (4) @(negedge clk);
                rst_miso = spi_miso;
                rst_oe   = spi_miso_oe;
                rst      = 1'b0;
                repeat (gap) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b1; rst = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({reg_addr, reg_wr_data, reg_wr, reg_rd, frame_err, busy, spi_miso, spi_miso_oe} !==
            {16'h0, 32'h0, 6'b000010}) begin
            n_bad++;
            $display("FAIL reset_hold: got %h/%h flags %b want 0/0 flags 000010",
                     reg_addr, reg_wr_data, {reg_wr, reg_rd, frame_err, busy, spi_miso, spi_miso_oe});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({reg_wr, reg_rd, frame_err, busy, spi_miso, spi_miso_oe} !== 6'b000010) begin
            n_bad++;
            $display("FAIL reset_release: got flags %b want 000010",
                     {reg_wr, reg_rd, frame_err, busy, spi_miso, spi_miso_oe});
        end
    endtask

    task automatic test_write();
        logic [55:0] f = {8'h02, 16'h0010, 32'hDEADBEEF};
        clear_obs();
        model(f, 56, 0);
        spi_xfer(f, 56, 0, 2*HALF);
        n_cmp++;
        if (ev_sig(obs_q) !== ev_sig(exp_q)) begin
            n_bad++;
            $display("FAIL write_events: got %h want %h", ev_sig(obs_q), ev_sig(exp_q));
        end
        n_cmp++;
        if ({rx_busy[56], busy, err_cnt} !== {1'b1, 1'b0, 32'(exp_err)}) begin
            n_bad++;
            $display("FAIL write_busy_err: got busy %b/%b err %0d want 1/0 err %0d",
                     rx_busy[56], busy, err_cnt, exp_err);
        end
    endtask

    task automatic test_read();
        logic [55:0] f = {RD, 16'h0004, 32'($urandom)};
        logic [31:0] got, oe_v;
        clear_obs();
        rd_val = 32'h12345678;
        model(f, 56, 0);
        spi_xfer(f, 56, 0, 2*HALF);
        for (int i = 0; i < 32; i++) begin
            got[31-i]  = rx_miso[25+i];
            oe_v[31-i] = rx_oe[25+i];
        end
        n_cmp++;
        if (ev_sig(obs_q) !== ev_sig(exp_q) || err_cnt != exp_err) begin
            n_bad++;
            $display("FAIL read_events: got %h err %0d want %h err %0d",
                     ev_sig(obs_q), err_cnt, ev_sig(exp_q), exp_err);
        end
        n_cmp++;
        if (got !== 32'h12345678) begin
            n_bad++;
            $display("FAIL read_miso: got %h want 12345678", got);
        end
        n_cmp++;
        if ({oe_v, rx_oe[24], rx_miso[24], spi_miso_oe, spi_miso} !== {32'hFFFFFFFF, 4'b0101}) begin
            n_bad++;
            $display("FAIL read_oe: got %h %b%b%b%b want ffffffff 0101",
                     oe_v, rx_oe[24], rx_miso[24], spi_miso_oe, spi_miso);
        end
    endtask

    task automatic test_early_end();
        logic [55:0] f = {8'h02, 16'h0020, 32'hCAFEF00D};
        logic [55:0] g = {8'h33, 16'h0024, 32'h0BADC0DE};
        clear_obs();
        model(f, 30, 0);
        spi_xfer(f, 30, 0, 2*HALF);
        n_cmp++;
        if (ev_sig(obs_q) !== ev_sig(exp_q) || err_cnt != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL early_end: got %h err %0d busy %b want %h err 1 busy 0",
                     ev_sig(obs_q), err_cnt, busy, ev_sig(exp_q));
        end
        clear_obs();
        model(g, 56, 0);
        spi_xfer(g, 56, 0, 2*HALF);
        n_cmp++;
        if (ev_sig(obs_q) !== ev_sig(exp_q) || err_cnt != 0) begin
            n_bad++;
            $display("FAIL early_end_next: got %h err %0d want %h err 0",
                     ev_sig(obs_q), err_cnt, ev_sig(exp_q));
        end
    endtask

    task automatic test_back_to_back();
        logic [55:0] f = {8'hA5, 16'h1234, 32'h89ABCDEF};
        logic [55:0] g = {RD, 16'h5678, 32'h0};
        logic [31:0] got;
        clear_obs();
        rd_val = 32'hF00DFACE;
        model(f, 56, 0);
        model(g, 56, 0);
        spi_xfer(f, 56, 0, 2*HALF);
        spi_xfer(g, 56, 0, 2*HALF);
        for (int i = 0; i < 32; i++) got[31-i] = rx_miso[25+i];
        n_cmp++;
        if (ev_sig(obs_q) !== ev_sig(exp_q) || err_cnt != 0) begin
            n_bad++;
            $display("FAIL b2b_events: got %h err %0d want %h err 0",
                     ev_sig(obs_q), err_cnt, ev_sig(exp_q));
        end
        n_cmp++;
        if (got !== rd_val) begin
            n_bad++;
            $display("FAIL b2b_miso: got %h want %h", got, rd_val);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [55:0] f = {RD, 16'h0040, 32'h0};
        logic [55:0] g = {8'h01, 16'h0044, 32'h13579BDF};
        clear_obs();
        rd_val = 32'hAAAA5555;
        model(f, 56, 40);
        spi_xfer(f, 56, 40, 2*HALF);
        n_cmp++;
        if ({rst_oe, rst_miso} !== 2'b01 || err_cnt != 0 || ev_sig(obs_q) !== ev_sig(exp_q)) begin
            n_bad++;
            $display("FAIL rst_mid_read: got oe %b miso %b err %0d ev %h want oe 0 miso 1 err 0 ev %h",
                     rst_oe, rst_miso, err_cnt, ev_sig(obs_q), ev_sig(exp_q));
        end
        clear_obs();
        model(g, 56, 0);
        spi_xfer(g, 56, 0, 2*HALF);
        n_cmp++;
        if (ev_sig(obs_q) !== ev_sig(exp_q) || err_cnt != 0) begin
            n_bad++;
            $display("FAIL rst_next_write: got %h err %0d want %h err 0",
                     ev_sig(obs_q), err_cnt, ev_sig(exp_q));
        end
    endtask

    task automatic test_extra_edges();
        logic [55:0] f = {8'h7E, 16'hBEEF, 32'h2468ACE1};
        clear_obs();
        model(f, 60, 0);
        spi_xfer(f, 60, 0, 2*HALF);
        n_cmp++;
        if (ev_sig(obs_q) !== ev_sig(exp_q) || err_cnt != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL extra_edges: got %h err %0d busy %b want %h err 0 busy 0",
                     ev_sig(obs_q), err_cnt, busy, ev_sig(exp_q));
        end
    endtask

    task automatic test_random();
        logic [55:0] f;
        logic [7:0]  cmd;
        logic [31:0] got;
        int          n;
        for (int k = 0; k < 16; k++) begin
            cmd = ($urandom_range(0, 1) == 0) ? RD : 8'($urandom);
            if (k % 2 == 1 && cmd == RD) cmd = 8'h0E;
            f = {cmd, 16'($urandom), 32'($urandom)};
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 55) : $urandom_range(56, 60);
            rd_val = $urandom;
            clear_obs();
            model(f, n, 0);
            spi_xfer(f, n, 0, $urandom_range(2*HALF, 4*HALF));
            n_cmp++;
            if (ev_sig(obs_q) !== ev_sig(exp_q) || err_cnt != exp_err || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_%0d: got %h err %0d busy %b want %h err %0d busy 0",
                         k, ev_sig(obs_q), err_cnt, busy, ev_sig(exp_q), exp_err);
            end
            if (cmd == RD && n >= 56) begin
                for (int i = 0; i < 32; i++) got[31-i] = rx_miso[25+i];
                n_cmp++;
                if (got !== rd_val) begin
                    n_bad++;
                    $display("FAIL rand_miso_%0d: got %h want %h", k, got, rd_val);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_early_end();
        test_back_to_back();
        test_reset_mid_read();
        test_extra_edges();
        test_random();
        n_cmp++;
        if (both_cnt != 0) begin
            n_bad++;
            $display("FAIL strobe_overlap: got %0d cycles want 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
